// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port indices for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin winner select, favouring the port not served last
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);
  always_comb begin
    grant_valid = |req;
    grant_idx   = &req ? ~last : req[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory between fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [addWidth-1:0]  addr0,
  input  logic [addWidth-1:0]  addr1,
  input  logic [dataWidth-1:0] wdata0,
  input  logic [dataWidth-1:0] wdata1,
  output logic [1:0]           ack,
  output logic [dataWidth-1:0] rdata,
  output logic                 mem_we,
  output logic [addWidth-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_in,
  input  logic [dataWidth-1:0] mem_out
);
  state_t state;
  logic   sel;
  logic   last;
  logic   grant_valid;
  logic   grant_idx;
  rr_arbiter2 u_rr (
    .req        (req),
    .last       (last),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );
  // mem_* double as the request register, so the memory sees only flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= PORT_FETCH;
      last     <= PORT_LSU;
      ack      <= '0;
      rdata    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_in   <= '0;
    end else
      case (state)
        IDLE:
          if (grant_valid) begin
            state    <= ACCESS;
            sel      <= grant_idx;
            last     <= grant_idx;
            mem_we   <= we[grant_idx];
            mem_addr <= grant_idx == PORT_FETCH ? addr0 : addr1;
            mem_in   <= grant_idx == PORT_FETCH ? wdata0 : wdata1;
          end
        ACCESS: begin
          state  <= RESP;
          mem_we <= 1'b0;
          rdata  <= mem_we ? rdata : mem_out;
          ack    <= sel == PORT_LSU ? 2'b10 : 2'b01;
        end
        RESP: begin
          state <= IDLE;
          ack   <= '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, write isolation and reset abort
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [5:0]  addr0 = '0;
  logic [5:0]  addr1 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic [31:0] mem [64];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.addWidth(6), .dataWidth(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack     (ack),
    .rdata   (rdata),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_in  (mem_in),
    .mem_out (mem_out)
  );
  assign mem_out = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input int p, input logic w, input logic [5:0] a, input logic [31:0] d);
    req[p] = 1'b1;
    we[p]  = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
  endtask
  task automatic xact(input string tag, input int p, input logic w, input logic [5:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    drive(p, w, a, d);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_we"}, 32'(mem_we), 32'(w));
    if (w) chk({tag, "_in"}, mem_in, d);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), p == 0 ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    req[p] = 1'b0;
    we[p]  = 1'b0;
  endtask
  initial begin
    logic [1:0]  seq [4];
    logic [31:0] rds [4];
    int          cyc [4];
    int          n;
    mem[1]  <= 32'hAAAA5555;
    mem[3]  <= 32'h0;
    mem[5]  <= 32'hDEADBEEF;
    mem[7]  <= 32'h77777777;
    mem[10] <= 32'h10101010;
    mem[20] <= 32'h20202020;
    mem[63] <= 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_in", mem_in, 32'd0);
    rst_n = 1'b1;
    xact("rd5", 0, 1'b0, 6'd5, 32'd0, 32'hDEADBEEF);
    xact("wr63", 1, 1'b1, 6'd63, 32'h12345678, 32'hDEADBEEF);
    chk("wr63_mem", mem[63], 32'h12345678);
    xact("rd63", 0, 1'b0, 6'd63, 32'd0, 32'h12345678);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 6'd5, 32'd0);
    drive(1, 1'b0, 6'd63, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        seq[n] = ack;
        rds[n] = rdata;
        cyc[n] = c;
        n++;
      end
    end
    req = '0;
    chk("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_ack%0d", i), 32'(seq[i]), i % 2 == 0 ? 32'd1 : 32'd2);
      chk($sformatf("rr_rd%0d", i), rds[i], i % 2 == 0 ? 32'hDEADBEEF : 32'h12345678);
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(cyc[i] - cyc[i-1]), 32'd3);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 6'd10, 32'd0);
    @(posedge clk); #1;
    addr0 = 6'd20;
    @(negedge clk);
    chk("chg_addr", 32'(mem_addr), 32'd10);
    @(negedge clk);
    chk("chg_ack", 32'(ack), 32'd1);
    chk("chg_rdata", rdata, 32'h10101010);
    req = '0;
    @(posedge clk); #1;
    drive(1, 1'b1, 6'd7, 32'h00000BAD);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_fall", 32'(mem_we), 32'd0);
    req = '0;
    we = '0;
    @(negedge clk);
    chk("rstw_mem", mem[7], 32'h77777777);
    chk("rstw_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack != 2'b00) n++;
    end
    chk("rstw_noack", 32'(n), 32'd0);
    xact("rd1", 0, 1'b0, 6'd1, 32'd0, 32'hAAAA5555);
    xact("wr3", 1, 1'b1, 6'd3, 32'h33333333, 32'hAAAA5555);
    chk("wr3_mem", mem[3], 32'h33333333);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
